// File: rtl/fu_pkg.sv
// Shared types for the function-unit stepper: mode-state enum and FS opcode constants.
package fu_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAGE   = 2'd2
  } mode_e;

  localparam int FS_W = 5;

  typedef logic [FS_W-1:0] fs_t;

  localparam fs_t FS_FIRST = 5'd0;
  localparam fs_t FS_LAST  = 5'd31;
  localparam fs_t FS_STEP  = 5'd1;

  // Advances through every opcode and wraps from the last back to the first.
  function automatic fs_t fs_next(input fs_t cur);
    return (cur == FS_LAST) ? FS_FIRST : cur + FS_STEP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Shift-register debouncer with rising-edge detect: a single press pulse per
// sustained button hold of DB_DEPTH samples.
module btn_debounce #(
  parameter int DB_DEPTH = 7
) (
  input  logic uclk,
  input  logic urst_n,
  input  logic btn,
  output logic pulse
);

  logic [DB_DEPTH-1:0] sr;
  logic                lvl;
  logic                prev;

  assign lvl   = &sr;
  assign pulse = lvl & ~prev;

  always_ff @(posedge uclk or negedge urst_n) begin
    if (!urst_n) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[DB_DEPTH-2:0], btn};
      prev <= lvl;
    end
  end

endmodule

// File: rtl/fu_stepper.sv
// Button-driven stepper that walks the function-select code of a function unit
// and shows its result nibbles and flags on eight LEDs.
// Build option: define FU_STEPPER_AUTO_EN to add the AUTO mode and its prescaler.
module fu_stepper
  import fu_pkg::*;
#(
  parameter int          WORD_SIZE = 32,
  parameter int          DB_DEPTH  = 7,
  parameter int          AUTO_DIV  = 24,
  parameter int unsigned IN_A      = 3,
  parameter int unsigned IN_B      = 2,
  parameter int unsigned SH_INIT   = 2
) (
  input  logic                 uclk,
  input  logic                 urst_n,
  input  logic                 btn_step,
  input  logic                 btn_mode,
  output logic [4:0]           fs,
  output logic [WORD_SIZE-1:0] a,
  output logic [WORD_SIZE-1:0] b,
  output logic [4:0]           sh,
  input  logic [WORD_SIZE-1:0] f,
  input  logic                 v,
  input  logic                 c,
  input  logic                 n,
  input  logic                 z,
  output logic [7:0]           led
);

  localparam int NPAGE  = WORD_SIZE / 4;
  localparam int PAGE_W = (NPAGE > 1) ? $clog2(NPAGE) : 1;
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(NPAGE - 1);

  logic step_pulse, mode_pulse;
  mode_e state_q, state_d;
  fs_t fs_q;
  logic [PAGE_W-1:0] page_q;
  logic fs_inc, page_inc, page_clr;

  btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_step (
    .uclk(uclk), .urst_n(urst_n), .btn(btn_step), .pulse(step_pulse)
  );

  btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_mode (
    .uclk(uclk), .urst_n(urst_n), .btn(btn_mode), .pulse(mode_pulse)
  );

`ifdef FU_STEPPER_AUTO_EN
  logic [AUTO_DIV-1:0] presc_q;
  logic presc_tc, presc_run, presc_clr;

  assign presc_tc = &presc_q;

  always_ff @(posedge uclk or negedge urst_n) begin
    if (!urst_n)        presc_q <= '0;
    else if (presc_clr) presc_q <= '0;
    else if (presc_run) presc_q <= presc_q + AUTO_DIV'(1);
  end
`else
  // AUTO_DIV only sizes the prescaler, which this build leaves out.
  if (AUTO_DIV < 1) begin : g_auto_div_unused
  end
`endif

  always_ff @(posedge uclk or negedge urst_n) begin
    if (!urst_n) state_q <= MANUAL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_pulse) begin
      case (state_q)
`ifdef FU_STEPPER_AUTO_EN
        MANUAL:  state_d = AUTO;
        AUTO:    state_d = PAGE;
`else
        MANUAL:  state_d = PAGE;
`endif
        PAGE:    state_d = MANUAL;
        default: state_d = MANUAL;
      endcase
    end
  end

  // A mode press always wins: the step pulse and any auto tick in that cycle are dropped.
  always_comb begin
    fs_inc    = 1'b0;
    page_inc  = 1'b0;
    page_clr  = 1'b0;
`ifdef FU_STEPPER_AUTO_EN
    presc_run = 1'b0;
    presc_clr = 1'b0;
`endif
    if (mode_pulse) begin
      page_clr = (state_q == PAGE);
`ifdef FU_STEPPER_AUTO_EN
      presc_clr = (state_d == AUTO);
`endif
    end else begin
      case (state_q)
        MANUAL: fs_inc = step_pulse;
`ifdef FU_STEPPER_AUTO_EN
        AUTO: begin
          presc_run = 1'b1;
          fs_inc    = presc_tc;
        end
`endif
        PAGE:    page_inc = step_pulse;
        default: ;
      endcase
    end
  end

  always_ff @(posedge uclk or negedge urst_n) begin
    if (!urst_n)     fs_q <= FS_FIRST;
    else if (fs_inc) fs_q <= fs_next(fs_q);
  end

  always_ff @(posedge uclk or negedge urst_n) begin
    if (!urst_n)       page_q <= '0;
    else if (page_clr) page_q <= '0;
    else if (page_inc) page_q <= (page_q == PAGE_MAX) ? '0 : page_q + PAGE_W'(1);
  end

  always_comb begin
    led[7:4] = {z, n, c, v};
    if (state_q == PAGE) led[3:0] = f[{page_q, 2'b00} +: 4];
    else                 led[3:0] = f[3:0];
  end

  assign fs = fs_q;
  assign a  = WORD_SIZE'(IN_A);
  assign b  = WORD_SIZE'(IN_B);
  assign sh = 5'(SH_INIT);

endmodule

// File: tb/tb_fu_stepper.sv
// Self-checking bench for fu_stepper: directed scenarios plus randomized button
// traffic compared against a behavioural model of the stepper.
module tb_fu_stepper;
  localparam int WS = 32;
  localparam int DB = 7;
  localparam int AD = 4;
  localparam int NP = WS / 4;

  logic uclk = 1'b0, urst_n = 1'b0, btn_step = 1'b0, btn_mode = 1'b0;
  logic [WS-1:0] f = '0;
  logic v = 1'b0, c = 1'b0, n = 1'b0, z = 1'b0;
  logic [4:0] fs, sh;
  logic [WS-1:0] a, b;
  logic [7:0] led;

  int total = 0;
  int bad = 0;

  always #5 uclk = ~uclk;

  fu_stepper #(
    .WORD_SIZE(WS), .DB_DEPTH(DB), .AUTO_DIV(AD), .IN_A(3), .IN_B(2), .SH_INIT(2)
  ) dut (
    .uclk(uclk), .urst_n(urst_n), .btn_step(btn_step), .btn_mode(btn_mode),
    .fs(fs), .a(a), .b(b), .sh(sh), .f(f), .v(v), .c(c), .n(n), .z(z), .led(led)
  );

  // Behavioural model: counts consecutive high samples per button, mode 0/1/2 = MANUAL/AUTO/PAGE.
  int m_run_s = 0, m_run_m = 0, m_mode = 0, m_page = 0, m_presc = 0;
  logic m_prev_s = 1'b0, m_prev_m = 1'b0;
  logic [4:0] m_fs = '0;
  logic m_sp, m_mp;

  assign m_sp = (m_run_s >= DB) && !m_prev_s;
  assign m_mp = (m_run_m >= DB) && !m_prev_m;

  function automatic int next_mode(input int md);
`ifdef FU_STEPPER_AUTO_EN
    return (md + 1) % 3;
`else
    return (md == 0) ? 2 : 0;
`endif
  endfunction

  function automatic logic [7:0] exp_led();
    logic [3:0] nib;
    nib = (m_mode == 2) ? 4'(f >> (4 * m_page)) : f[3:0];
    return {z, n, c, v, nib};
  endfunction

  always @(posedge uclk or negedge urst_n) begin
    if (!urst_n) begin
      m_run_s <= 0; m_run_m <= 0; m_prev_s <= 1'b0; m_prev_m <= 1'b0;
      m_mode <= 0; m_page <= 0; m_presc <= 0; m_fs <= '0;
    end else begin
      m_run_s  <= btn_step ? ((m_run_s < DB) ? m_run_s + 1 : m_run_s) : 0;
      m_run_m  <= btn_mode ? ((m_run_m < DB) ? m_run_m + 1 : m_run_m) : 0;
      m_prev_s <= (m_run_s >= DB);
      m_prev_m <= (m_run_m >= DB);
      if (m_mp) begin
        m_mode <= next_mode(m_mode);
        m_page <= 0;
        m_presc <= 0;
      end else if (m_mode == 0) begin
        if (m_sp) m_fs <= m_fs + 5'd1;
      end else if (m_mode == 1) begin
        if (m_presc == (1 << AD) - 1) begin
          m_fs <= m_fs + 5'd1;
          m_presc <= 0;
        end else begin
          m_presc <= m_presc + 1;
        end
      end else if (m_sp) begin
        m_page <= (m_page + 1) % NP;
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge uclk);
  endtask

  task automatic do_reset();
    @(negedge uclk);
    urst_n = 1'b0; btn_step = 1'b0; btn_mode = 1'b0;
    cyc(2);
    urst_n = 1'b1;
  endtask

  task automatic press_step();
    btn_step = 1'b1; cyc(DB + 1); btn_step = 1'b0; cyc(2);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(DB + 1); btn_mode = 1'b0; cyc(2);
  endtask

  task automatic test_reset();
    @(negedge uclk);
    f = 32'hCAFE_F00D; v = 1'b1; c = 1'b0; n = 1'b1; z = 1'b0;
    urst_n = 1'b0; btn_step = 1'b1;
    #1;
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL reset_fs got=%0d exp=0", fs); end
    total++; if (a !== 32'd3) begin bad++; $display("FAIL const_a got=%0h exp=3", a); end
    total++; if (b !== 32'd2) begin bad++; $display("FAIL const_b got=%0h exp=2", b); end
    total++; if (sh !== 5'd2) begin bad++; $display("FAIL const_sh got=%0d exp=2", sh); end
    total++; if (led !== 8'b0101_1101) begin bad++; $display("FAIL reset_led got=%b exp=01011101", led); end
    cyc(12);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL reset_hold_fs got=%0d exp=0", fs); end
    btn_step = 1'b0;
    urst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_step_press();
    do_reset();
    btn_step = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 7) begin
        total++; if (fs !== 5'd0) begin bad++; $display("FAIL step_edge7 got=%0d exp=0", fs); end
      end
    end
    total++; if (fs !== 5'd1) begin bad++; $display("FAIL step_edge8 got=%0d exp=1", fs); end
    cyc(100);
    total++; if (fs !== 5'd1) begin bad++; $display("FAIL step_held got=%0d exp=1", fs); end
    btn_step = 1'b0; cyc(2);

    do_reset();
    btn_step = 1'b1; cyc(6); btn_step = 1'b0; cyc(10);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL step_short got=%0d exp=0", fs); end

    for (int i = 0; i < 31; i++) press_step();
    total++; if (fs !== 5'd31) begin bad++; $display("FAIL step_to31 got=%0d exp=31", fs); end
    press_step();
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL step_wrap got=%0d exp=0", fs); end

    // Reset during a press must restart the debounce from scratch.
    do_reset();
    btn_step = 1'b1; cyc(5);
    urst_n = 1'b0; #1;
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL midpress_rst got=%0d exp=0", fs); end
    cyc(1); urst_n = 1'b1;
    cyc(7);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL midpress_early got=%0d exp=0", fs); end
    cyc(1);
    total++; if (fs !== 5'd1) begin bad++; $display("FAIL midpress_fresh got=%0d exp=1", fs); end
    btn_step = 1'b0; cyc(2);
  endtask

`ifdef FU_STEPPER_AUTO_EN
  task automatic test_auto();
    logic [4:0] fs0;
    int guard;
    do_reset();
    btn_mode = 1'b1; cyc(DB + 1); btn_mode = 1'b0;
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL auto_enter got=%0d exp=0", fs); end
    cyc(15);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL auto_pre16 got=%0d exp=0", fs); end
    cyc(1);
    total++; if (fs !== 5'd1) begin bad++; $display("FAIL auto_16 got=%0d exp=1", fs); end
    cyc(16);
    total++; if (fs !== 5'd2) begin bad++; $display("FAIL auto_32 got=%0d exp=2", fs); end
    for (int i = 0; i < 3; i++) begin
      press_step();
      total++; if (fs !== m_fs) begin bad++; $display("FAIL auto_step_ignored got=%0d exp=%0d", fs, m_fs); end
    end
    guard = 0;
    while (m_presc != 8 && guard < 40) begin cyc(1); guard++; end
    total++; if (guard >= 40) begin bad++; $display("FAIL auto_tc_align got=timeout exp=presc8"); end
    fs0 = fs;
    btn_mode = 1'b1; cyc(DB + 1); btn_mode = 1'b0;
    total++; if (fs !== fs0) begin bad++; $display("FAIL auto_tc_mode got=%0d exp=%0d", fs, fs0); end
    cyc(2);
    press_mode(); press_mode();
    cyc(40);
    total++; if (fs !== m_fs) begin bad++; $display("FAIL auto_run got=%0d exp=%0d", fs, m_fs); end
    urst_n = 1'b0; #1;
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL auto_rst got=%0d exp=0", fs); end
    cyc(1); urst_n = 1'b1;
    cyc(40);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL auto_rst_manual got=%0d exp=0", fs); end
  endtask
`else
  task automatic test_no_auto();
    do_reset();
    press_mode();
    cyc(100);
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL noauto_idle got=%0d exp=0", fs); end
    press_step(); press_step();
    total++; if (fs !== 5'd0) begin bad++; $display("FAIL noauto_page_step got=%0d exp=0", fs); end
    press_mode();
    press_step();
    total++; if (fs !== 5'd1) begin bad++; $display("FAIL noauto_manual got=%0d exp=1", fs); end
  endtask
`endif

  task automatic enter_page();
`ifdef FU_STEPPER_AUTO_EN
    press_mode(); press_mode();
`else
    press_mode();
`endif
  endtask

  task automatic test_page();
    logic [3:0] exp_nib [8];
    exp_nib = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd8};
    do_reset();
    f = 32'h1234_5678; v = 1'b1; c = 1'b0; n = 1'b0; z = 1'b1;
    enter_page();
    total++; if (led[3:0] !== 4'd8) begin bad++; $display("FAIL page0 got=%0d exp=8", led[3:0]); end
    total++; if (led[7:4] !== 4'b1001) begin bad++; $display("FAIL page_flags got=%b exp=1001", led[7:4]); end
    for (int i = 0; i < 8; i++) begin
      press_step();
      total++;
      if (led[3:0] !== exp_nib[i]) begin
        bad++; $display("FAIL page_step%0d got=%0d exp=%0d", i, led[3:0], exp_nib[i]);
      end
    end
    press_step(); press_step(); press_step();
    total++; if (led[3:0] !== 4'd5) begin bad++; $display("FAIL page_pre_leave got=%0d exp=5", led[3:0]); end
    press_mode();
    enter_page();
    total++; if (led[3:0] !== 4'd8) begin bad++; $display("FAIL page_cleared got=%0d exp=8", led[3:0]); end
  endtask

  task automatic test_coincide();
    do_reset();
    press_step(); press_step();
    btn_step = 1'b1; btn_mode = 1'b1;
    cyc(DB + 1);
    btn_step = 1'b0; btn_mode = 1'b0;
    cyc(2);
    total++; if (fs !== 5'd2) begin bad++; $display("FAIL both_fs got=%0d exp=2", fs); end
`ifdef FU_STEPPER_AUTO_EN
    cyc(13);
    total++; if (fs !== 5'd2) begin bad++; $display("FAIL both_auto_pre got=%0d exp=2", fs); end
    cyc(1);
    total++; if (fs !== 5'd3) begin bad++; $display("FAIL both_auto_tick got=%0d exp=3", fs); end
`else
    f = 32'h1234_5678;
    press_step();
    total++; if (led[3:0] !== 4'd7) begin bad++; $display("FAIL both_page got=%0d exp=7", led[3:0]); end
    total++; if (fs !== 5'd2) begin bad++; $display("FAIL both_page_fs got=%0d exp=2", fs); end
`endif
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      btn_step = 1'($urandom_range(0, 1));
      btn_mode = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        cyc(1);
        total++; if (fs !== m_fs) begin bad++; $display("FAIL rand_fs got=%0d exp=%0d", fs, m_fs); end
        total++; if (led !== exp_led()) begin bad++; $display("FAIL rand_led got=%b exp=%b", led, exp_led()); end
        f = $urandom; {v, c, n, z} = 4'($urandom);
        if ($urandom_range(0, 299) == 0) begin
          urst_n = 1'b0; #1;
          total++; if (fs !== 5'd0) begin bad++; $display("FAIL rand_rst got=%0d exp=0", fs); end
          cyc(1); urst_n = 1'b1;
        end
      end
    end
    btn_step = 1'b0; btn_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step_press();
`ifdef FU_STEPPER_AUTO_EN
    test_auto();
`else
    test_no_auto();
`endif
    test_page();
    test_coincide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
